// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller.
// Holds the operand-mux select encoding, default widths and the select-priority helper.
// Pure declarations: no latency, no flow control.
package fwd_hazard_ctrl_pkg;

  localparam int DEF_REG_AW = 5;   // 32 GPRs
  localparam int DEF_CNT_W  = 32;  // performance counter width
  localparam int REG_ZERO   = 0;   // $0 is hard-wired zero and never forwarded

  // EX-stage operand mux select encoding
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,  // register file value
    FWD_WB  = 2'd1,  // MEM/WB pipeline register result
    FWD_MEM = 2'd2   // EX/MEM pipeline register result
  } fwd_sel_e;

  // Nearest producer wins: the instruction one stage ahead beats the one two stages ahead.
  function automatic fwd_sel_e pick_sel(input logic ex_match, input logic mem_match);
    if (ex_match) begin
      return FWD_MEM;
    end
    if (mem_match) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Interface bundling the ID-stage hazard inputs and the controller's select/stall outputs.
// master = pipeline datapath (drives ID info, flush, mem_wait); slave = hazard controller.
// Ports: id_* instruction fields, flush, mem_wait -> fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt, fwd_cnt.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;
  logic              mem_wait;

  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall;
  logic              bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  fwd_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_memread,
    output flush, mem_wait,
    input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt, fwd_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_memread,
    input  flush, mem_wait,
    output fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt, fwd_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_select.sv
// fwd_select: picks the operand mux source for one EX operand from the EX and MEM shadow records.
// Latency: purely combinational; the caller registers the result on the EX-entry edge.
// Backpressure: none; the caller gates use_src when the operand is unused or the slot is a bubble.
// Ports: src/use_src (operand), ex_* and mem_* producer records -> sel.
import fwd_hazard_ctrl_pkg::*;

module fwd_select #(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dst,
  output fwd_sel_e          sel
);

  logic ex_match;
  logic mem_match;

  // A producer writing $0 never forwards: the register file already returns zero.
  assign ex_match  = use_src & ex_valid & ex_regwrite &
                     (ex_dst != REG_AW'(REG_ZERO)) & (ex_dst == src);
  assign mem_match = use_src & mem_valid & mem_regwrite &
                     (mem_dst != REG_AW'(REG_ZERO)) & (mem_dst == src);

  assign sel = pick_sel(ex_match, mem_match);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand forwarding selects and load-use stall/bubble for the 5-stage MIPS pipe.
// Latency: selects registered on the edge an instruction enters EX; stall/bubble combinational.
// Backpressure: mem_wait freezes all records and selects; stall holds PC and IF/ID for one cycle.
// Ports: clk, rst_n (async active-low), bus (fwd_hazard_ctrl_if.slave).
// Optional feature macro HAZ_PERF_CNT_EN: builds saturating stall_cnt/fwd_cnt (tied to 0 otherwise).
import fwd_hazard_ctrl_pkg::*;

module fwd_hazard_ctrl #(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  fwd_hazard_ctrl_if.slave    bus
);

  // Shadow of the instruction currently in EX; memread is needed for load-use detection.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } ex_rec_t;

  // Shadow of the instruction in MEM. A WB-stage producer needs no record: the register
  // file writes before it reads, so the ID-stage read already sees the WB result.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
  } mem_rec_t;

  ex_rec_t  ex_q;
  mem_rec_t mem_q;
  fwd_sel_e sel_a_q;
  fwd_sel_e sel_b_q;
  fwd_sel_e sel_a_d;
  fwd_sel_e sel_b_d;

  logic load_hit;
  logic stall;
  logic bubble;
  logic enter_ex;

  // Load in EX whose result the ID instruction needs: it is not available until after MEM.
  assign load_hit = ex_q.valid & ex_q.memread & ex_q.regwrite &
                    (ex_q.dst != REG_AW'(REG_ZERO)) & bus.id_valid &
                    ((bus.id_use_rs & (bus.id_rs == ex_q.dst)) |
                     (bus.id_use_rt & (bus.id_rt == ex_q.dst)));

  // A frozen pipeline cannot stall or bubble; a flushed instruction is discarded instead of held.
  assign stall    = load_hit & ~bus.flush & ~bus.mem_wait;
  assign bubble   = stall | (bus.flush & ~bus.mem_wait);
  assign enter_ex = bus.id_valid & ~bubble;

  // Selects are computed from the pre-edge records: the current EX occupant will be in MEM
  // (EX/MEM result) and the current MEM occupant in WB (MEM/WB result) once the ID instruction
  // reaches EX. Gating use_src with enter_ex forces 0 for bubbles and invalid slots.
  fwd_select #(.REG_AW(REG_AW)) u_sel_a (
    .src          (bus.id_rs),
    .use_src      (bus.id_use_rs & enter_ex),
    .ex_valid     (ex_q.valid),
    .ex_regwrite  (ex_q.regwrite),
    .ex_dst       (ex_q.dst),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_dst      (mem_q.dst),
    .sel          (sel_a_d)
  );

  fwd_select #(.REG_AW(REG_AW)) u_sel_b (
    .src          (bus.id_rt),
    .use_src      (bus.id_use_rt & enter_ex),
    .ex_valid     (ex_q.valid),
    .ex_regwrite  (ex_q.regwrite),
    .ex_dst       (ex_q.dst),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_dst      (mem_q.dst),
    .sel          (sel_b_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else if (!bus.mem_wait) begin
      mem_q.valid    <= ex_q.valid;
      mem_q.dst      <= ex_q.dst;
      mem_q.regwrite <= ex_q.regwrite;
      if (enter_ex) begin
        ex_q.valid    <= 1'b1;
        ex_q.dst      <= bus.id_dst;
        ex_q.regwrite <= bus.id_regwrite;
        ex_q.memread  <= bus.id_memread;
      end else begin
        ex_q <= '0;
      end
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign bus.fwd_a_sel = sel_a_q;
  assign bus.fwd_b_sel = sel_b_q;
  assign bus.stall     = stall;
  assign bus.bubble    = bubble;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_q;
  logic             fwd_event;

  // Counts instructions entering EX that use at least one bypass path.
  assign fwd_event = enter_ex & ((sel_a_d != FWD_RF) | (sel_b_d != FWD_RF));

  // Both counters saturate so long runs never wrap back to a misleading small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!bus.mem_wait) begin
      if (stall && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (fwd_event && !(&fwd_cnt_q)) begin
        fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed pipeline scenarios followed by random traffic,
// every cycle compared against an instruction-level model of the in-flight producers.
// Works with or without HAZ_PERF_CNT_EN defined.
module tb_fwd_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: list of the producers ahead of ID, youngest first (index 0 = in EX, 1 = in MEM).
  typedef struct {
    bit v;
    int dst;
    bit rw;
    bit mr;
  } prod_t;

  prod_t inflight[$];
  int    e_a, e_b;       // expected selects of the instruction in EX
  int    e_stl, e_fwd;   // expected counter values
  bit    last_stall, last_bubble;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    prod_t p;
    p.v = 0; p.dst = 0; p.rw = 0; p.mr = 0;
    inflight = {};
    inflight.push_back(p);
    inflight.push_back(p);
    e_a = 0; e_b = 0; e_stl = 0; e_fwd = 0;
  endtask

  // Nearest writer of src among the producers ahead: one stage ahead -> EX/MEM (2), two -> MEM/WB (1).
  function automatic int nearest(input int src);
    for (int d = 0; d < 2; d++) begin
      if (inflight[d].v && inflight[d].rw && inflight[d].dst != 0 && inflight[d].dst == src)
        return (d == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int dst, input bit rw, input bit mr);
    bus.id_valid    = v;
    bus.id_rs       = AW'(rs);
    bus.id_rt       = AW'(rt);
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_dst      = AW'(dst);
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
  endtask

  task automatic check_cnts();
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", bus.stall_cnt, e_stl);
    chk("fwd_cnt", bus.fwd_cnt, e_fwd);
`else
    chk("stall_cnt_tied", bus.stall_cnt, 0);
    chk("fwd_cnt_tied", bus.fwd_cnt, 0);
`endif
  endtask

  // One pipeline cycle: called at posedge+1 with ID inputs applied; returns at the next posedge+1.
  task automatic tick(input bit fl, input bit mw);
    bit    hit, es, eb, ent;
    int    na, nb;
    prod_t p;
    bus.flush    = fl;
    bus.mem_wait = mw;
    @(negedge clk);
    hit = bus.id_valid && inflight[0].v && inflight[0].mr && inflight[0].rw &&
          inflight[0].dst != 0 &&
          ((bus.id_use_rs && int'(bus.id_rs) == inflight[0].dst) ||
           (bus.id_use_rt && int'(bus.id_rt) == inflight[0].dst));
    es = hit && !fl && !mw;
    eb = es || (fl && !mw);
    chk("stall", bus.stall, es);
    chk("bubble", bus.bubble, eb);
    last_stall  = es;
    last_bubble = eb;
    if (!mw) begin
      ent = bus.id_valid && !eb;
      na  = (ent && bus.id_use_rs) ? nearest(int'(bus.id_rs)) : 0;
      nb  = (ent && bus.id_use_rt) ? nearest(int'(bus.id_rt)) : 0;
      if (es) e_stl++;
      if (ent && (na != 0 || nb != 0)) e_fwd++;
      e_a = na;
      e_b = nb;
      p.v   = ent;
      p.dst = ent ? int'(bus.id_dst) : 0;
      p.rw  = ent && bus.id_regwrite;
      p.mr  = ent && bus.id_memread;
      inflight.push_front(p);
      void'(inflight.pop_back());
    end
    @(posedge clk);
    #1;
    chk("fwd_a_sel", bus.fwd_a_sel, e_a);
    chk("fwd_b_sel", bus.fwd_b_sel, e_b);
    check_cnts();
  endtask

  initial begin
    bit hold;
    int rs, rt, dst;
    bit v, urs, urt, rw, mr, fl, mw;

    // ---- reset state ----
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 0; bus.mem_wait = 0;
    model_reset();
    #2;
    chk("rst_a", bus.fwd_a_sel, 0);
    chk("rst_b", bus.fwd_b_sel, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_bubble", bus.bubble, 0);
    check_cnts();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- add $3 ; add $4,$3,$3 -> both operands from EX/MEM ----
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick(0, 0);
    set_id(1, 3, 3, 1, 1, 4, 1, 0); tick(0, 0);
    chk("exfwd_a", bus.fwd_a_sel, 2);
    chk("exfwd_b", bus.fwd_b_sel, 2);
    chk("exfwd_nostall", last_stall, 0);

    // ---- asynchronous reset mid-stream with non-zero selects ----
    set_id(1, 4, 4, 1, 1, 5, 1, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_a", bus.fwd_a_sel, 0);
    chk("midrst_b", bus.fwd_b_sel, 0);
    chk("midrst_stall", bus.stall, 0);
    @(negedge clk);
    chk("midrst_stall2", bus.stall, 0);
    @(posedge clk); #1;
    chk("midrst_a2", bus.fwd_a_sel, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    set_id(1, 3, 3, 1, 1, 7, 1, 0); tick(0, 0);
    chk("postrst_a", bus.fwd_a_sel, 0);
    chk("postrst_b", bus.fwd_b_sel, 0);

    // ---- add $3 ; nop ; sub $5,$3,$1 -> A from MEM/WB ----
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick(0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0); tick(0, 0);
    set_id(1, 3, 1, 1, 1, 5, 1, 0); tick(0, 0);
    chk("wbfwd_a", bus.fwd_a_sel, 1);
    chk("wbfwd_b", bus.fwd_b_sel, 0);

    // ---- add $3 ; add $3 ; sub $5,$3,$1 -> nearest producer wins ----
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick(0, 0);
    set_id(1, 2, 2, 1, 1, 3, 1, 0); tick(0, 0);
    set_id(1, 3, 1, 1, 1, 5, 1, 0); tick(0, 0);
    chk("nearest_a", bus.fwd_a_sel, 2);

    // ---- lw $2 ; add $6,$2,$0 -> one stall, then MEM/WB forward ----
    set_id(1, 0, 0, 1, 0, 2, 1, 1); tick(0, 0);
    set_id(1, 2, 0, 1, 1, 6, 1, 0); tick(0, 0);
    chk("lu_stall", last_stall, 1);
    chk("lu_bubble", last_bubble, 1);
    tick(0, 0);
    chk("lu_nostall2", last_stall, 0);
    chk("lu_a", bus.fwd_a_sel, 1);
    chk("lu_b", bus.fwd_b_sel, 0);
`ifdef HAZ_PERF_CNT_EN
    chk("lu_stall_cnt", bus.stall_cnt, 1);
`endif

    // ---- load-use with flush in the same cycle -> no stall, bubble ----
    set_id(1, 0, 0, 1, 0, 2, 1, 1); tick(0, 0);
    set_id(1, 2, 0, 1, 1, 6, 1, 0); tick(1, 0);
    chk("fl_stall", last_stall, 0);
    chk("fl_bubble", last_bubble, 1);
    chk("fl_a", bus.fwd_a_sel, 0);

    // ---- add $3 ; lw $2,0($3) ; consumer under mem_wait x3 -> frozen, then resumes ----
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick(0, 0);
    set_id(1, 3, 0, 1, 0, 2, 1, 1); tick(0, 0);
    set_id(1, 2, 0, 1, 1, 6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1);
      chk("mw_stall", last_stall, 0);
      chk("mw_bubble", last_bubble, 0);
      chk("mw_hold_a", bus.fwd_a_sel, 2);
    end
    tick(0, 0);
    chk("mw_resume_stall", last_stall, 1);
    tick(0, 0);
    chk("mw_resume_a", bus.fwd_a_sel, 1);

    // ---- writes to $0 never forward or stall ----
    set_id(1, 1, 1, 1, 1, 0, 1, 0); tick(0, 0);
    set_id(1, 0, 0, 1, 1, 8, 1, 0); tick(0, 0);
    chk("zero_a", bus.fwd_a_sel, 0);
    chk("zero_b", bus.fwd_b_sel, 0);
    set_id(1, 0, 0, 1, 0, 0, 1, 1); tick(0, 0);
    set_id(1, 0, 0, 1, 1, 9, 1, 0); tick(0, 0);
    chk("zero_lw_stall", last_stall, 0);

    // ---- random traffic; a stalled or frozen ID instruction is re-presented ----
    hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        v   = ($urandom_range(7) != 0);
        rs  = $urandom_range(3);
        rt  = $urandom_range(3);
        dst = $urandom_range(3);
        urs = $urandom_range(1);
        urt = $urandom_range(1);
        rw  = ($urandom_range(3) != 0);
        mr  = rw && ($urandom_range(2) == 0);
        set_id(v, rs, rt, urs, urt, dst, rw, mr);
      end
      fl = ($urandom_range(15) == 0);
      mw = ($urandom_range(7) == 0);
      tick(fl, mw);
      hold = mw || last_stall;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
